// File: rtl/fft_butterfly.sv
// fft_butterfly: first radix-2 DIF stage of a 512-point streaming FFT, 16 complex lanes per cycle
module fft_butterfly #(
  parameter int IN_WIDTH  = 9,
  parameter int OUT_WIDTH = 10,
  parameter int NUM       = 16,
  parameter int N         = 512
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     valid_in,
  input  logic [IN_WIDTH*NUM-1:0]  din_i,
  input  logic [IN_WIDTH*NUM-1:0]  din_q,
  output logic                     valid_out,
  output logic [OUT_WIDTH*NUM-1:0] do1_re,
  output logic [OUT_WIDTH*NUM-1:0] do1_im
);
  localparam int DEPTH = N / (2 * NUM);
  localparam int CW    = $clog2(DEPTH);
  typedef enum logic [1:0] {FILL, SUM, DRAIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [OUT_WIDTH*NUM-1:0] buf_re_q [DEPTH];
  logic [OUT_WIDTH*NUM-1:0] buf_im_q [DEPTH];
  logic [OUT_WIDTH*NUM-1:0] c_re, c_im, sum_re, sum_im, dif_re, dif_im;
  logic [OUT_WIDTH*NUM-1:0] re_q, im_q, re_d, im_d, tail_re, tail_im;
  logic valid_q, emit, shift, last_blk;
  for (genvar j = 0; j < NUM; j++) begin : g_lane
    assign c_re[j*OUT_WIDTH +: OUT_WIDTH] = {{(OUT_WIDTH-IN_WIDTH){din_i[j*IN_WIDTH+IN_WIDTH-1]}}, din_i[j*IN_WIDTH +: IN_WIDTH]};
    assign c_im[j*OUT_WIDTH +: OUT_WIDTH] = {{(OUT_WIDTH-IN_WIDTH){din_q[j*IN_WIDTH+IN_WIDTH-1]}}, din_q[j*IN_WIDTH +: IN_WIDTH]};
    assign sum_re[j*OUT_WIDTH +: OUT_WIDTH] = buf_re_q[0][j*OUT_WIDTH +: OUT_WIDTH] + c_re[j*OUT_WIDTH +: OUT_WIDTH];
    assign sum_im[j*OUT_WIDTH +: OUT_WIDTH] = buf_im_q[0][j*OUT_WIDTH +: OUT_WIDTH] + c_im[j*OUT_WIDTH +: OUT_WIDTH];
    assign dif_re[j*OUT_WIDTH +: OUT_WIDTH] = buf_re_q[0][j*OUT_WIDTH +: OUT_WIDTH] - c_re[j*OUT_WIDTH +: OUT_WIDTH];
    assign dif_im[j*OUT_WIDTH +: OUT_WIDTH] = buf_im_q[0][j*OUT_WIDTH +: OUT_WIDTH] - c_im[j*OUT_WIDTH +: OUT_WIDTH];
  end
  // DRAIN advances every cycle; FILL and SUM advance only on accepted blocks
  assign emit     = state_q == DRAIN || (state_q == SUM && valid_in);
  assign shift    = state_q == DRAIN || valid_in;
  assign last_blk = cnt_q == CW'(DEPTH - 1);
  assign tail_re  = state_q == SUM ? dif_re : c_re;
  assign tail_im  = state_q == SUM ? dif_im : c_im;
  assign re_d     = state_q == DRAIN ? buf_re_q[0] : sum_re;
  assign im_d     = state_q == DRAIN ? buf_im_q[0] : sum_im;
  always_comb begin
    state_d = state_q;
    if (shift && last_blk)
      case (state_q)
        FILL:    state_d = SUM;
        SUM:     state_d = DRAIN;
        default: state_d = FILL;
      endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= FILL;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= emit;
      if (shift) cnt_q <= cnt_q + CW'(1);
      if (emit) begin
        re_q <= re_d;
        im_q <= im_d;
      end
    end
  end
  // buffer contents are don't-care after reset, so it carries no reset
  always_ff @(posedge clk) begin
    if (shift) begin
      for (int k = 0; k < DEPTH - 1; k++) begin
        buf_re_q[k] <= buf_re_q[k+1];
        buf_im_q[k] <= buf_im_q[k+1];
      end
      buf_re_q[DEPTH-1] <= tail_re;
      buf_im_q[DEPTH-1] <= tail_im;
    end
  end
  assign valid_out = valid_q;
  assign do1_re    = re_q;
  assign do1_im    = im_q;
endmodule

// File: tb/tb_fft_butterfly.sv
// tb_fft_butterfly: directed frame vectors with hand-computed sums/differences and output timing checks
module tb_fft_butterfly;
  localparam int IW = 9, OW = 10, NUM = 16;
  typedef struct {
    string name;
    bit    ramp;
    int    a_re, a_im, c_re, c_im;
    int    s_re, s_im, d_re, d_im;
  } vec_t;
  logic clk = 1'b0, rstn = 1'b0, valid_in = 1'b0;
  logic [IW*NUM-1:0] din_i = '0, din_q = '0;
  logic valid_out;
  logic [OW*NUM-1:0] do1_re, do1_im;
  int n_chk = 0, n_err = 0, cyc = 0;
  logic [OW*NUM-1:0] q_re[$], q_im[$];
  int q_cyc[$];
  vec_t tbl[3];
  fft_butterfly dut (
    .clk(clk), .rstn(rstn), .valid_in(valid_in), .din_i(din_i), .din_q(din_q),
    .valid_out(valid_out), .do1_re(do1_re), .do1_im(do1_im)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1;
    if (valid_out) begin
      q_re.push_back(do1_re);
      q_im.push_back(do1_im);
      q_cyc.push_back(cyc);
    end
  end
  task automatic check(string name, logic signed [159:0] act, logic signed [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic int xval(vec_t v, int b, int j, bit im);
    if (b < 16) return v.ramp ? (im ? 0 : 16*b + j - 128) : (im ? v.a_im : v.a_re);
    return v.ramp ? (im ? 0 : 1) : (im ? v.c_im : v.c_re);
  endfunction
  function automatic int eval(vec_t v, int k, int j, bit im);
    if (k < 16) return v.ramp ? (im ? 0 : 16*k + j - 127) : (im ? v.s_im : v.s_re);
    return v.ramp ? (im ? 0 : 16*(k-16) + j - 129) : (im ? v.d_im : v.d_re);
  endfunction
  task automatic drive_block(vec_t v, int b);
    for (int j = 0; j < NUM; j++) begin
      din_i[j*IW +: IW] = IW'(xval(v, b, j, 1'b0));
      din_q[j*IW +: IW] = IW'(xval(v, b, j, 1'b1));
    end
    valid_in = 1'b1;
  endtask
  task automatic run_frame(vec_t v, bit gapped, bit junk_drain);
    int k16, k31;
    logic [OW*NUM-1:0] e_re, e_im;
    q_re.delete(); q_im.delete(); q_cyc.delete();
    for (int b = 0; b < 32; b++) begin
      @(negedge clk);
      drive_block(v, b);
      if (b == 16) k16 = cyc;
      if (b == 31) k31 = cyc;
      if (gapped) begin
        @(negedge clk);
        valid_in = 1'b0;
        din_i = '1;
      end
    end
    for (int d = 0; d < 16; d++) begin
      @(negedge clk);
      valid_in = junk_drain;
      din_i = IW*NUM'($urandom);
      din_q = IW*NUM'($urandom);
    end
    @(negedge clk);
    valid_in = 1'b0;
    check({v.name, " count"}, q_re.size(), 32);
    if (q_re.size() == 32) begin
      check({v.name, " sum latency"}, q_cyc[0], k16 + 1);
      check({v.name, " diff latency"}, q_cyc[16], k31 + 2);
      check({v.name, " sum span"}, q_cyc[15] - q_cyc[0], gapped ? 30 : 15);
      check({v.name, " drain span"}, q_cyc[31] - q_cyc[16], 15);
      for (int k = 0; k < 32; k++) begin
        for (int j = 0; j < NUM; j++) begin
          e_re[j*OW +: OW] = OW'(eval(v, k, j, 1'b0));
          e_im[j*OW +: OW] = OW'(eval(v, k, j, 1'b1));
        end
        check($sformatf("%s blk%0d re", v.name, k), q_re[k], e_re);
        check($sformatf("%s blk%0d im", v.name, k), q_im[k], e_im);
      end
    end
  endtask
  initial begin
    tbl[0] = '{"const",   1'b0, 10, -3, 10, -3, 20, -6, 0, 0};
    tbl[1] = '{"extreme", 1'b0, 255, -256, -256, 255, -1, -1, 511, -511};
    tbl[2] = '{"ramp",    1'b1, 0, 0, 0, 0, 0, 0, 0, 0};
    valid_in = 1'b1;
    din_i = '1;
    din_q = '1;
    repeat (2) @(negedge clk);
    check("reset valid_out", valid_out, 0);
    check("reset do1_re", do1_re, 0);
    check("reset do1_im", do1_im, 0);
    valid_in = 1'b0;
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) run_frame(tbl[i], 1'b0, i == 0);
    run_frame(tbl[2], 1'b1, 1'b0);
    for (int b = 0; b <= 20; b++) begin
      @(negedge clk);
      drive_block(tbl[2], b);
    end
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset valid_out", valid_out, 0);
    check("midreset do1_re", do1_re, 0);
    check("midreset do1_im", do1_im, 0);
    valid_in = 1'b0;
    rstn = 1'b1;
    run_frame(tbl[0], 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
